// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone path: note and octave codes,
// mid-octave half-period constants at 100 MHz, and the tone FSM states.
package piano_pkg;

    // Note codes as delivered by the key-to-note controller
    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_DO   = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SO   = 3'd5;
    localparam logic [2:0] NOTE_LA   = 3'd6;
    localparam logic [2:0] NOTE_XI   = 3'd7;

    // Octave codes; code 3 is handled as the mid octave
    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    // Mid-octave half periods in 100 MHz clock cycles
    localparam int unsigned HALF_DO = 191110;
    localparam int unsigned HALF_RE = 170265;
    localparam int unsigned HALF_MI = 151685;
    localparam int unsigned HALF_FA = 143172;
    localparam int unsigned HALF_SO = 127551;
    localparam int unsigned HALF_LA = 113636;
    localparam int unsigned HALF_XI = 101239;

    // Tone generator states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        STOP = 2'd2
    } tone_state_t;

    // True when an 8-bit note index names a real pitch (1..7)
    function automatic logic note_is_pitch(input logic [7:0] idx);
        return (idx != 8'd0) && (idx <= 8'd7);
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Bundle of the note request inputs and the buzzer/status outputs of the
// tone generator. The master side requests notes, the slave side plays them.
interface note_tone_gen_if;
    logic [7:0] note;
    logic [1:0] octave;
    logic       enable;
    logic       buzzer;
    logic       playing;
    logic [2:0] cur_note;
    logic       cycle_tick;

    modport master (
        output note, octave, enable,
        input  buzzer, playing, cur_note, cycle_tick
    );

    modport slave (
        input  note, octave, enable,
        output buzzer, playing, cur_note, cycle_tick
    );
endinterface

// File: rtl/note_period_lut.sv
// Combinational map from (note, octave) to half-period in clock cycles.
// The octave shift is applied first, then SCALE_SHIFT, then a floor of 2
// so the tone counter always has at least two states per phase.
module note_period_lut
    import piano_pkg::*;
#(
    parameter int SCALE_SHIFT = 0,
    parameter int CNT_W       = 19
) (
    input  logic [2:0]       note,
    input  logic [1:0]       octave,
    output logic [CNT_W-1:0] half
);

    localparam int LW = CNT_W + 1;

    logic [LW-1:0] base;
    logic [LW-1:0] shifted;
    logic [LW-1:0] scaled;

    // Table lookup, octave scaling, simulation scaling and clamp
    always_comb begin
        base = '0;
        case (note)
            NOTE_DO: base = LW'(HALF_DO);
            NOTE_RE: base = LW'(HALF_RE);
            NOTE_MI: base = LW'(HALF_MI);
            NOTE_FA: base = LW'(HALF_FA);
            NOTE_SO: base = LW'(HALF_SO);
            NOTE_LA: base = LW'(HALF_LA);
            NOTE_XI: base = LW'(HALF_XI);
            default: base = '0;
        endcase

        shifted = base;
        case (octave)
            OCT_LOW:  shifted = base << 1;
            OCT_HIGH: shifted = base >> 1;
            default:  shifted = base;
        endcase

        scaled = shifted >> SCALE_SHIFT;

        if (scaled < LW'(2)) begin
            half = CNT_W'(2);
        end else begin
            half = scaled[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave buzzer driver. Pitch changes are only adopted on half-period
// boundaries so no phase is ever cut short, and a rest request lets a high
// phase run to completion before the buzzer goes quiet.
module note_tone_gen
    import piano_pkg::*;
#(
    parameter int SCALE_SHIFT = 0,
    parameter int CNT_W       = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    note_tone_gen_if.slave  bus
);

    logic [2:0]       target_note;
    logic [1:0]       target_oct;
    logic [CNT_W-1:0] lut_half;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] counter;
    tone_state_t      state;
    logic             buzzer;
    logic             playing;
    logic [2:0]       cur_note;
    logic             cycle_tick;
    logic             target_rest;
    logic             at_boundary;

    assign target_rest = (target_note == NOTE_REST);
    assign at_boundary = (counter == half - CNT_W'(1));

    assign bus.buzzer     = buzzer;
    assign bus.playing    = playing;
    assign bus.cur_note   = cur_note;
    assign bus.cycle_tick = cycle_tick;

    note_period_lut #(
        .SCALE_SHIFT (SCALE_SHIFT),
        .CNT_W       (CNT_W)
    ) u_lut (
        .note   (target_note),
        .octave (target_oct),
        .half   (lut_half)
    );

    // Register the request; disabled or out-of-range notes collapse to rest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_note <= NOTE_REST;
            target_oct  <= 2'd0;
        end else begin
            target_note <= (bus.enable && note_is_pitch(bus.note)) ? bus.note[2:0] : NOTE_REST;
            target_oct  <= bus.octave;
        end
    end

    // Tone FSM: start on a pitch, reload only on boundaries, finish high phases before stopping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            buzzer     <= 1'b0;
            playing    <= 1'b0;
            cur_note   <= NOTE_REST;
            cycle_tick <= 1'b0;
            counter    <= '0;
            half       <= '0;
        end else begin
            cycle_tick <= 1'b0;
            case (state)
                IDLE: begin
                    buzzer   <= 1'b0;
                    counter  <= '0;
                    playing  <= 1'b0;
                    cur_note <= NOTE_REST;
                    if (!target_rest) begin
                        half       <= lut_half;
                        cur_note   <= target_note;
                        buzzer     <= 1'b1;
                        cycle_tick <= 1'b1;
                        playing    <= 1'b1;
                        state      <= PLAY;
                    end
                end

                PLAY: begin
                    if (target_rest && !buzzer) begin
                        state   <= STOP;
                        counter <= '0;
                    end else if (at_boundary) begin
                        counter    <= '0;
                        buzzer     <= ~buzzer;
                        cycle_tick <= ~buzzer;
                        if (target_rest) begin
                            state    <= IDLE;
                            playing  <= 1'b0;
                            cur_note <= NOTE_REST;
                        end else begin
                            half     <= lut_half;
                            cur_note <= target_note;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                        if (target_rest) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (!buzzer) begin
                        state    <= IDLE;
                        playing  <= 1'b0;
                        cur_note <= NOTE_REST;
                        counter  <= '0;
                    end else if (at_boundary) begin
                        counter <= '0;
                        buzzer  <= 1'b0;
                        if (target_rest) begin
                            state    <= IDLE;
                            playing  <= 1'b0;
                            cur_note <= NOTE_REST;
                        end else begin
                            state    <= PLAY;
                            half     <= lut_half;
                            cur_note <= target_note;
                        end
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed and randomized bench for note_tone_gen with SCALE_SHIFT = 10.
// Expected half periods come from the note table and octave/scale rules.
module tb_note_tone_gen;

    localparam int SHIFT = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    note_tone_gen_if bus ();

    note_tone_gen #(
        .SCALE_SHIFT (SHIFT),
        .CNT_W       (19)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;

    // Expected half period in cycles for a request; 0 means rest
    function automatic int expHalf(input int n, input int oct);
        int base [8] = '{0, 191110, 170265, 151685, 143172, 127551, 113636, 101239};
        int v;
        if (n < 1 || n > 7) return 0;
        v = base[n];
        if (oct == 0) v = v * 2;
        else if (oct == 2) v = v / 2;
        v = v / (1 << SHIFT);
        if (v < 2) v = 2;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.cycle_tick === 1'b1) tick_cnt++;
    endtask

    task automatic applyStimulus(input logic [7:0] n, input logic [1:0] o, input logic en);
        bus.note   = n;
        bus.octave = o;
        bus.enable = en;
    endtask

    // Length of the phase in progress, counted from the current sample
    task automatic measure(output int len);
        logic lvl;
        lvl = bus.buzzer;
        len = 0;
        while (bus.buzzer === lvl && len < 4000) begin
            len++;
            step();
        end
    endtask

    task automatic riseLatency(output int lat);
        lat = 0;
        while (bus.buzzer !== 1'b1 && lat < 4000) begin
            step();
            lat++;
        end
    endtask

    task automatic toLowStart();
        int d;
        if (bus.buzzer === 1'b0) measure(d);
        measure(d);
    endtask

    task automatic quietWindow(input string tag, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            step();
            if (bus.buzzer !== 1'b0 || bus.playing !== 1'b0) hits++;
        end
        checkOutput(tag, hits, 0);
    endtask

    task automatic goIdle();
        int w;
        w = 0;
        applyStimulus(8'd0, 2'd1, 1'b1);
        while (bus.playing !== 1'b0 && w < 4000) begin
            step();
            w++;
        end
        checkOutput("go_idle", bus.playing, 0);
        step();
    endtask

    // Rest seen during a low phase: quiet within three samples, buzzer never rises
    task automatic restInLow(input string tag, input logic [7:0] n, input logic en);
        int hi;
        hi = 0;
        repeat (10) step();
        applyStimulus(n, 2'd1, en);
        repeat (3) begin
            step();
            if (bus.buzzer !== 1'b0) hi++;
        end
        checkOutput({tag, "_playing"}, bus.playing, 0);
        checkOutput({tag, "_cur_note"}, bus.cur_note, 0);
        checkOutput({tag, "_buzzer_low"}, hi, 0);
    endtask

    initial begin
        int lat, len, n, o, n2, o2, ev, ev2;
        logic en;

        $display("[TB] note_tone_gen bench start");
        rst_n = 1'b0;
        applyStimulus(8'd0, 2'd1, 1'b1);
        repeat (3) step();
        checkOutput("reset_buzzer", bus.buzzer, 0);
        checkOutput("reset_playing", bus.playing, 0);
        checkOutput("reset_cur_note", bus.cur_note, 0);
        checkOutput("reset_tick", bus.cycle_tick, 0);
        rst_n = 1'b1;
        step();

        // do, mid octave
        tick_cnt = 0;
        applyStimulus(8'd1, 2'd1, 1'b1);
        riseLatency(lat);
        checkOutput("do_latency", lat, 2);
        checkOutput("do_cur_note", bus.cur_note, 1);
        checkOutput("do_playing", bus.playing, 1);
        checkOutput("do_first_tick", tick_cnt, 1);
        measure(len); checkOutput("do_high", len, 186);
        measure(len); checkOutput("do_low", len, 186);
        checkOutput("do_tick_period1", tick_cnt, 2);
        measure(len); checkOutput("do_high2", len, 186);
        measure(len); checkOutput("do_low2", len, 186);
        checkOutput("do_tick_period2", tick_cnt, 3);

        // pitch change do -> la in the middle of a high phase
        repeat (50) step();
        applyStimulus(8'd6, 2'd1, 1'b1);
        measure(len); checkOutput("chg_rest_of_high", len, 136);
        measure(len); checkOutput("chg_la_low", len, 110);
        checkOutput("chg_cur_note", bus.cur_note, 6);
        measure(len); checkOutput("chg_la_high", len, 110);
        measure(len); checkOutput("chg_la_low2", len, 110);

        // octave low with do, then octave high with la
        applyStimulus(8'd1, 2'd0, 1'b1);
        measure(len); checkOutput("oct_low_cur", len, 110);
        measure(len); checkOutput("oct_low_a", len, expHalf(1, 0));
        measure(len); checkOutput("oct_low_b", len, 373);
        applyStimulus(8'd6, 2'd2, 1'b1);
        measure(len); checkOutput("oct_high_cur", len, 373);
        measure(len); checkOutput("oct_high_a", len, 55);
        measure(len); checkOutput("oct_high_b", len, expHalf(6, 2));

        // rest during a high phase
        repeat (20) step();
        applyStimulus(8'd0, 2'd2, 1'b1);
        measure(len); checkOutput("rest_high_finish", len, 35);
        step();
        checkOutput("rest_high_playing", bus.playing, 0);
        checkOutput("rest_high_cur_note", bus.cur_note, 0);
        checkOutput("rest_high_buzzer", bus.buzzer, 0);
        quietWindow("rest_high_quiet", 400);

        // rest during a low phase
        applyStimulus(8'd3, 2'd1, 1'b1);
        riseLatency(lat);
        checkOutput("mi_latency", lat, 2);
        measure(len); checkOutput("mi_high", len, 148);
        restInLow("rest_low", 8'd0, 1'b1);
        quietWindow("rest_low_quiet", 300);

        // enable = 0 during a high phase
        applyStimulus(8'd2, 2'd1, 1'b1);
        riseLatency(lat);
        checkOutput("re_latency", lat, 2);
        repeat (20) step();
        applyStimulus(8'd2, 2'd1, 1'b0);
        measure(len); checkOutput("dis_high_finish", len, 146);
        step();
        checkOutput("dis_high_playing", bus.playing, 0);
        quietWindow("dis_high_quiet", 300);

        // enable = 0 during a low phase
        applyStimulus(8'd2, 2'd1, 1'b1);
        riseLatency(lat);
        toLowStart();
        restInLow("dis_low", 8'd2, 1'b0);
        quietWindow("dis_low_quiet", 300);

        // out-of-range note indices behave as rest
        applyStimulus(8'd8, 2'd1, 1'b1);
        quietWindow("note8_quiet", 300);
        applyStimulus(8'h80, 2'd1, 1'b1);
        quietWindow("note80_quiet", 300);

        // octave 3 behaves as mid
        applyStimulus(8'd1, 2'd3, 1'b1);
        riseLatency(lat);
        checkOutput("oct3_latency", lat, 2);
        measure(len); checkOutput("oct3_high", len, 186);
        measure(len); checkOutput("oct3_low", len, 186);

        // one-cycle reset in the middle of a note
        repeat (30) step();
        rst_n = 1'b0;
        step();
        checkOutput("midrst_buzzer", bus.buzzer, 0);
        checkOutput("midrst_playing", bus.playing, 0);
        checkOutput("midrst_cur_note", bus.cur_note, 0);
        checkOutput("midrst_tick", bus.cycle_tick, 0);
        rst_n = 1'b1;
        riseLatency(lat);
        checkOutput("midrst_restart_latency", lat, 2);
        checkOutput("midrst_cur_note_after", bus.cur_note, 1);
        measure(len); checkOutput("midrst_high", len, 186);
        goIdle();

        // randomized requests from idle, followed by a pitch change
        for (int i = 0; i < 8; i++) begin
            n  = $urandom_range(0, 12);
            o  = $urandom_range(0, 3);
            en = ($urandom_range(0, 5) != 0);
            ev = en ? expHalf(n, o) : 0;
            applyStimulus(8'(n), 2'(o), en);
            if (ev == 0) begin
                quietWindow("rnd_rest_quiet", 60);
            end else begin
                riseLatency(lat);
                checkOutput("rnd_latency", lat, 2);
                checkOutput("rnd_cur_note", bus.cur_note, n);
                measure(len); checkOutput("rnd_high", len, ev);
                measure(len); checkOutput("rnd_low", len, ev);
                n2  = $urandom_range(1, 7);
                o2  = $urandom_range(0, 3);
                ev2 = expHalf(n2, o2);
                applyStimulus(8'(n2), 2'(o2), 1'b1);
                measure(len); checkOutput("rnd_chg_cur", len, ev);
                measure(len); checkOutput("rnd_chg_new", len, ev2);
                checkOutput("rnd_chg_cur_note", bus.cur_note, n2);
                goIdle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
